// File: rtl/ram_share_arbiter_if.sv
// ram_share_arbiter_if
//   Bundles the requester-side handshake and the shared work-RAM side port
//   of ram_share_arbiter.
//   Requester side : req, req_addr (N*AW packed), req_wdata (N*8 packed),
//                    req_we, gnt (one-hot), rdata.
//   RAM side       : ram_addr, ram_din, ram_we, ram_dout (1-cycle latency).
//   Modports: slave  = arbiter view.
//             master = requesters plus RAM, i.e. everything outside the arbiter.
interface ram_share_arbiter_if #(
   parameter int N  = 2,
   parameter int AW = 12
);
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N*8-1:0]  req_wdata;
   logic [N-1:0]    req_we;
   logic [N-1:0]    gnt;
   logic [7:0]      rdata;
   logic [AW-1:0]   ram_addr;
   logic [7:0]      ram_din;
   logic            ram_we;
   logic [7:0]      ram_dout;

   modport slave (
      input  req, req_addr, req_wdata, req_we, ram_dout,
      output gnt, rdata, ram_addr, ram_din, ram_we
   );

   modport master (
      output req, req_addr, req_wdata, req_we, ram_dout,
      input  gnt, rdata, ram_addr, ram_din, ram_we
   );
endinterface

// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter
//   Shares the core's single work-RAM side port between N background
//   requesters. The core is paused and allowed to settle for SETTLE cycles
//   before the first grant. Grants are then handed round-robin without
//   re-settling until no requester remains, at which point pause is released.
//   Ports:
//     clk_sys, reset_n      : clock, synchronous active-low reset
//     user_pause, osd_pause : external pause sources merged into pause
//     bus (slave)           : requester handshake and shared RAM port
//     pause                 : pause line to the core
//     busy                  : arbiter not idle
module ram_share_arbiter #(
   parameter int N      = 2,
   parameter int AW     = 12,
   parameter int SETTLE = 4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              user_pause,
   input  logic              osd_pause,
   ram_share_arbiter_if.slave bus,
   output logic              pause,
   output logic              busy
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GRANT, ST_HANDOVER} state_t;

   state_t        state, state_nx;
   logic [SW-1:0] sel, sel_nx;
   logic [SW-1:0] ptr, ptr_nx;
   logic [SW-1:0] pick, cand;
   logic          pick_any;
   logic [7:0]    cnt, cnt_nx;
   logic [AW-1:0] addr_q, cur_addr;
   logic [7:0]    din_q, cur_din, rdata_q;
   logic [N-1:0]  gnt_c;
   logic          granted;

   // Round-robin search upward from the requester after the last one granted.
   always_comb begin
      pick_any = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = SW'((32'(ptr) + k) % N);
         if (!pick_any && bus.req[cand]) begin
            pick_any = 1'b1;
            pick     = cand;
         end
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               sel_nx   = pick;
               cnt_nx   = 8'(SETTLE - 1);
               state_nx = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            // A dropped requester is replaced without restarting the settle
            // count; the core has already been paused that long.
            if (!bus.req[sel] && !pick_any) begin
               state_nx = ST_IDLE;
            end else begin
               if (!bus.req[sel]) sel_nx = pick;
               if (cnt == '0) state_nx = ST_GRANT;
               else           cnt_nx   = cnt - 8'd1;
            end
         end
         ST_GRANT: begin
            if (!bus.req[sel]) begin
               ptr_nx   = sel;
               state_nx = pick_any ? ST_HANDOVER : ST_IDLE;
            end
         end
         ST_HANDOVER: begin
            // ptr already points at the released requester here.
            if (pick_any) begin
               sel_nx   = pick;
               state_nx = ST_GRANT;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         sel     <= '0;
         ptr     <= SW'(N - 1);
         cnt     <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_nx;
         sel     <= sel_nx;
         ptr     <= ptr_nx;
         cnt     <= cnt_nx;
         rdata_q <= bus.ram_dout;
         if (granted) begin
            addr_q <= cur_addr;
            din_q  <= cur_din;
         end
      end
   end

   assign granted  = (state == ST_GRANT);
   assign cur_addr = bus.req_addr[int'(sel) * AW +: AW];
   assign cur_din  = bus.req_wdata[int'(sel) * 8 +: 8];

   always_comb begin
      gnt_c = '0;
      if (granted) gnt_c[sel] = 1'b1;
   end

   assign bus.gnt      = gnt_c;
   assign bus.ram_we   = granted & bus.req_we[sel] & bus.req[sel];
   assign bus.ram_addr = granted ? cur_addr : addr_q;
   assign bus.ram_din  = granted ? cur_din : din_q;
   assign bus.rdata    = rdata_q;

   assign busy  = (state != ST_IDLE);
   assign pause = user_pause | osd_pause | busy;
endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter
//   Directed bench for ram_share_arbiter (N=2, AW=12, SETTLE=4) with a
//   4K x 8 synchronous RAM model on the shared port.
module tb_ram_share_arbiter;
   logic clk_sys    = 1'b0;
   logic reset_n    = 1'b0;
   logic user_pause = 1'b0;
   logic osd_pause  = 1'b0;
   logic pause, busy;

   int total  = 0;
   int passed = 0;

   ram_share_arbiter_if #(.N(2), .AW(12)) bus ();

   ram_share_arbiter #(.N(2), .AW(12), .SETTLE(4)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .user_pause (user_pause),
      .osd_pause  (osd_pause),
      .bus        (bus),
      .pause      (pause),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: reset fills a known pattern (addr[7:0] ^ 8'hB7), so 12'h010 holds 8'hA7.
   logic [7:0] mem [0:4095];
   always @(posedge clk_sys) begin
      if (!reset_n) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'hB7;
         bus.ram_dout <= 8'h00;
      end else begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
         bus.ram_dout <= mem[bus.ram_addr];
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic set_req(input int i, input logic r, input logic [11:0] a,
                          input logic [7:0] d, input logic we);
      bus.req[i]            = r;
      bus.req_addr[i*12 +: 12] = a;
      bus.req_wdata[i*8 +: 8]  = d;
      bus.req_we[i]         = we;
   endtask

   initial begin
      bus.req       = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_we    = '0;

      // Reset held with both requesters asking
      bus.req = 2'b11;
      repeat (4) tick();
      chk("rst_gnt", bus.gnt, 2'b00);
      chk("rst_we", bus.ram_we, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pause", pause, 1'b0);
      chk("rst_addr", bus.ram_addr, 12'h000);
      chk("rst_rdata", bus.rdata, 8'h00);
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("rel_busy", busy, 1'b1);
         chk("rel_gnt", bus.gnt, (i == 5) ? 2'b01 : 2'b00);
      end
      bus.req = 2'b00;
      tick();
      chk("rel_idle_busy", busy, 1'b0);
      chk("rel_idle_gnt", bus.gnt, 2'b00);

      // Single write from requester 0
      set_req(0, 1'b1, 12'h3A5, 8'h5C, 1'b1);
      tick();
      chk("wr_pause", pause, 1'b1);
      chk("wr_gnt_early", bus.gnt, 2'b00);
      chk("wr_we_settle", bus.ram_we, 1'b0);
      repeat (3) tick();
      chk("wr_gnt_t4", bus.gnt, 2'b00);
      tick();
      chk("wr_gnt", bus.gnt, 2'b01);
      chk("wr_we", bus.ram_we, 1'b1);
      chk("wr_addr", bus.ram_addr, 12'h3A5);
      chk("wr_din", bus.ram_din, 8'h5C);
      tick();
      chk("wr_gnt_hold", bus.gnt, 2'b01);
      bus.req[0] = 1'b0;
      #1;
      chk("wr_we_drop", bus.ram_we, 1'b0);
      tick();
      chk("wr_end_gnt", bus.gnt, 2'b00);
      chk("wr_end_busy", busy, 1'b0);
      chk("wr_end_pause", pause, 1'b0);
      chk("wr_hold_addr", bus.ram_addr, 12'h3A5);
      bus.req_we = 2'b00;

      // Read by requester 1: address presented at t, rdata valid at t+2
      set_req(1, 1'b1, 12'h010, 8'h00, 1'b0);
      repeat (5) tick();
      chk("rd_gnt", bus.gnt, 2'b10);
      chk("rd_addr", bus.ram_addr, 12'h010);
      chk("rd_we", bus.ram_we, 1'b0);
      tick();
      chk("rd_t1", bus.rdata, 8'h5C);
      tick();
      chk("rd_t2", bus.rdata, 8'hA7);
      bus.req = 2'b00;
      tick();
      chk("rd_end_busy", busy, 1'b0);

      // Round-robin with handover
      bus.req = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("rr_gnt", bus.gnt, (i == 5) ? 2'b01 : 2'b00);
      end
      repeat (2) tick();
      chk("rr_gnt_hold", bus.gnt, 2'b01);
      bus.req = 2'b10;
      tick();
      chk("rr_handover_gnt", bus.gnt, 2'b00);
      chk("rr_handover_busy", busy, 1'b1);
      chk("rr_handover_pause", pause, 1'b1);
      tick();
      chk("rr_gnt1", bus.gnt, 2'b10);
      bus.req = 2'b11;
      tick();
      chk("rr_no_preempt", bus.gnt, 2'b10);
      bus.req = 2'b00;
      tick();
      chk("rr_idle", busy, 1'b0);
      bus.req = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("rr_next0", bus.gnt, (i == 5) ? 2'b01 : 2'b00);
      end
      bus.req = 2'b00;
      tick();
      bus.req = 2'b11;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("rr_next1", bus.gnt, (i == 5) ? 2'b10 : 2'b00);
      end
      bus.req = 2'b00;
      tick();
      chk("rr_end_busy", busy, 1'b0);

      // Abort during settle
      bus.req = 2'b10;
      tick();
      chk("ab_busy", busy, 1'b1);
      tick();
      chk("ab_gnt", bus.gnt, 2'b00);
      bus.req = 2'b00;
      tick();
      chk("ab_idle_busy", busy, 1'b0);
      chk("ab_idle_pause", pause, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ab_no_gnt", bus.gnt, 2'b00);
         chk("ab_no_we", bus.ram_we, 1'b0);
      end

      // Pause merge
      user_pause = 1'b1;
      #1;
      chk("pm_user_pause", pause, 1'b1);
      chk("pm_user_busy", busy, 1'b0);
      chk("pm_user_gnt", bus.gnt, 2'b00);
      user_pause = 1'b0;
      #1;
      chk("pm_user_off", pause, 1'b0);
      bus.req = 2'b01;
      repeat (5) tick();
      chk("pm_gnt", bus.gnt, 2'b01);
      osd_pause = 1'b1;
      bus.req = 2'b00;
      tick();
      chk("pm_osd_busy", busy, 1'b0);
      chk("pm_osd_pause", pause, 1'b1);
      osd_pause = 1'b0;
      #1;
      chk("pm_osd_off", pause, 1'b0);

      // Reset in the middle of a granted write
      set_req(0, 1'b1, 12'h123, 8'h99, 1'b1);
      repeat (5) tick();
      chk("mr_gnt", bus.gnt, 2'b01);
      chk("mr_we", bus.ram_we, 1'b1);
      reset_n = 1'b0;
      tick();
      chk("mr_gnt_drop", bus.gnt, 2'b00);
      chk("mr_we_drop", bus.ram_we, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_addr", bus.ram_addr, 12'h000);
      chk("mr_rdata", bus.rdata, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
